// File: rtl/bypass_scoreboard.sv
// Decode-stage hazard unit: tracks in-flight destination tags and a single
// multi-cycle mult/div, producing forwarding selects and a load-use/md stall.
module bypass_scoreboard #(
    parameter int REG_BITS  = 5,
    parameter int DEPTH     = 3,
    parameter int MD_CYCLES = 33
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                issue_valid,
    input  logic [REG_BITS-1:0] issue_rd,
    input  logic                issue_wen,
    input  logic                issue_is_load,
    input  logic                issue_is_md,
    input  logic [REG_BITS-1:0] src_a,
    input  logic [REG_BITS-1:0] src_b,
    input  logic                src_a_used,
    input  logic                src_b_used,
    input  logic                flush,
    output logic                stall,
    output logic [2:0]          fwd_a,
    output logic [2:0]          fwd_b,
    output logic                md_busy
);

    localparam logic [7:0] MD_INIT = 8'(MD_CYCLES);

    logic [DEPTH:1]      v_q, wen_q, ld_q;
    logic [REG_BITS-1:0] rd_q [1:DEPTH];
    logic [7:0]          md_cnt_q, md_cnt_d;
    logic [REG_BITS-1:0] md_rd_q, md_rd_d;

    logic [DEPTH:1] prod;
    logic           load_use, md_dep, accept;

    always_comb begin
        prod  = '0;
        fwd_a = '0;
        fwd_b = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            prod[k] = v_q[k] & wen_q[k] & (rd_q[k] != '0);
        end
        // Scan oldest to youngest so the youngest matching producer wins.
        for (int k = DEPTH; k >= 1; k--) begin
            if (src_a_used && prod[k] && rd_q[k] == src_a) fwd_a = 3'(k);
            if (src_b_used && prod[k] && rd_q[k] == src_b) fwd_b = 3'(k);
        end
    end

    always_comb begin
        md_busy  = (md_cnt_q != '0);
        load_use = prod[1] & ld_q[1] &
                   ((src_a_used & (rd_q[1] == src_a)) | (src_b_used & (rd_q[1] == src_b)));
        md_dep   = md_busy & (issue_is_md |
                   ((md_rd_q != '0) & ((src_a_used & (src_a == md_rd_q)) |
                                       (src_b_used & (src_b == md_rd_q)))));
        stall    = issue_valid & ~flush & (load_use | md_dep);
        accept   = issue_valid & ~flush & ~stall;

        md_cnt_d = md_cnt_q;
        md_rd_d  = md_rd_q;
        if (accept && issue_is_md) begin
            md_cnt_d = MD_INIT;
            md_rd_d  = issue_rd;
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_q      <= '0;
            md_cnt_q <= '0;
            md_rd_q  <= '0;
        end else begin
            v_q      <= {v_q[DEPTH-1:1], accept};
            md_cnt_q <= md_cnt_d;
            md_rd_q  <= md_rd_d;
        end
    end

    // Tag payload is only meaningful under v_q, so it needs no reset.
    always_ff @(posedge clock) begin
        rd_q[1]  <= issue_rd;
        wen_q[1] <= issue_wen & ~issue_is_md;
        ld_q[1]  <= issue_is_load;
        for (int k = 2; k <= DEPTH; k++) begin
            rd_q[k]  <= rd_q[k-1];
            wen_q[k] <= wen_q[k-1];
            ld_q[k]  <= ld_q[k-1];
        end
    end

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed-vector bench: stimulus queues hand-computed expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_bypass_scoreboard;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       issue_valid = 1'b0, issue_wen = 1'b0, issue_is_load = 1'b0, issue_is_md = 1'b0;
    logic [4:0] issue_rd = '0, src_a = '0, src_b = '0;
    logic       src_a_used = 1'b0, src_b_used = 1'b0, flush = 1'b0;
    logic       stall, md_busy;
    logic [2:0] fwd_a, fwd_b;

    bypass_scoreboard #(.REG_BITS(5), .DEPTH(3), .MD_CYCLES(33)) dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wen(issue_wen),
        .issue_is_load(issue_is_load), .issue_is_md(issue_is_md),
        .src_a(src_a), .src_b(src_b), .src_a_used(src_a_used), .src_b_used(src_b_used),
        .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        stall;
        logic [2:0]  fa;
        logic [2:0]  fb;
        logic        busy;
        logic [15:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   chk_id  = 0;

    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (stall !== e.stall) begin
                n_fail++;
                $display("FAIL chk%0d stall: got %b expected %b", e.id, stall, e.stall);
            end
            n_tests++;
            if (fwd_a !== e.fa) begin
                n_fail++;
                $display("FAIL chk%0d fwd_a: got %0d expected %0d", e.id, fwd_a, e.fa);
            end
            n_tests++;
            if (fwd_b !== e.fb) begin
                n_fail++;
                $display("FAIL chk%0d fwd_b: got %0d expected %0d", e.id, fwd_b, e.fb);
            end
            n_tests++;
            if (md_busy !== e.busy) begin
                n_fail++;
                $display("FAIL chk%0d md_busy: got %b expected %b", e.id, md_busy, e.busy);
            end
        end
    end

    task automatic drive(input logic v, input int rd, input logic wen, input logic ld,
                         input logic md, input int sa, input logic au, input int sb,
                         input logic bu, input logic fl);
        issue_valid   = v;
        issue_rd      = 5'(rd);
        issue_wen     = wen;
        issue_is_load = ld;
        issue_is_md   = md;
        src_a         = 5'(sa);
        src_a_used    = au;
        src_b         = 5'(sb);
        src_b_used    = bu;
        flush         = fl;
    endtask

    task automatic expect_out(input logic es, input int efa, input int efb, input logic eb);
        exp_t e;
        e.stall = es;
        e.fa    = 3'(efa);
        e.fb    = 3'(efb);
        e.busy  = eb;
        e.id    = 16'(chk_id);
        chk_id++;
        exp_q.push_back(e);
    endtask

    // One decode cycle: drive after the edge, queue expectation, wait past the sample.
    task automatic cyc(input logic v, input int rd, input logic wen, input logic ld,
                       input logic md, input int sa, input logic au, input int sb,
                       input logic bu, input logic fl,
                       input logic es, input int efa, input int efb, input logic eb);
        @(posedge clock);
        #1;
        drive(v, rd, wen, ld, md, sa, au, sb, bu, fl);
        expect_out(es, efa, efb, eb);
        @(negedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: outputs idle even with used sources presented.
        cyc(1,0,0,0,0, 3,1, 4,1, 0,  0,0,0,0);
        reset_n = 1'b1;

        // add r3 on the first edge after reset, then add r4,r3,r3
        cyc(1,3,1,0,0, 0,0, 0,0, 0,  0,0,0,0);
        cyc(1,4,1,0,0, 3,1, 3,1, 0,  0,1,1,0);
        // r4 in between: r3 now at stage 2; this one writes r0
        cyc(1,0,1,0,0, 3,1, 3,1, 0,  0,2,2,0);
        // r0 never forwards; r3 at stage 3
        cyc(1,0,0,0,0, 0,1, 3,1, 0,  0,0,3,0);
        cyc(0,0,0,0,0, 4,1, 0,0, 0,  0,3,0,0);
        cyc(0,0,0,0,0, 4,1, 0,0, 0,  0,0,0,0);

        // r7 at stages 1 and 3, youngest wins
        cyc(1,7,1,0,0, 0,0, 0,0, 0,  0,0,0,0);
        cyc(1,9,1,0,0, 0,0, 0,0, 0,  0,0,0,0);
        cyc(1,7,1,0,0, 7,1, 0,0, 0,  0,2,0,0);
        cyc(0,0,0,0,0, 7,1, 9,1, 0,  0,1,2,0);

        // lw r5; add r6,r5,r0 stalls exactly one cycle
        cyc(1,5,1,1,0, 0,0, 0,0, 0,  0,0,0,0);
        cyc(1,6,1,0,0, 5,1, 0,1, 0,  1,1,0,0);
        cyc(1,6,1,0,0, 5,1, 0,1, 0,  0,2,0,0);

        // lw r11; dependent add flushed: no stall, bubble inserted
        cyc(1,11,1,1,0, 0,0, 0,0, 0,  0,0,0,0);
        cyc(1,12,1,0,0, 11,1, 0,0, 1, 0,1,0,0);
        cyc(1,0,0,0,0, 12,1, 11,1, 0, 0,0,2,0);

        // lw r13 followed by a matching bubble: no stall
        cyc(1,13,1,1,0, 0,0, 0,0, 0,  0,0,0,0);
        cyc(0,0,0,0,0, 13,1, 0,0, 0,  0,1,0,0);

        // mul r8 then add r9,r8: 33 stall cycles, then issue reading the register file
        cyc(1,8,1,0,1, 0,0, 0,0, 0,  0,0,0,0);
        for (int i = 0; i < 33; i++) begin
            cyc(1,9,1,0,0, 8,1, 0,0, 0,  1,0,0,1);
        end
        cyc(1,9,1,0,0, 8,1, 0,0, 0,  0,0,0,0);

        // Second mul: independent add, md-while-busy, flush, bubble
        cyc(1,8,1,0,1, 0,0, 0,0, 0,  0,0,0,0);
        cyc(1,9,1,0,0, 1,1, 0,0, 0,  0,0,0,1);
        cyc(1,2,1,0,1, 0,0, 0,0, 0,  1,0,0,1);
        cyc(1,9,1,0,0, 8,1, 0,0, 1,  0,0,0,1);
        cyc(0,9,1,0,0, 8,1, 0,0, 0,  0,0,0,1);
        for (int i = 0; i < 19; i++) begin
            cyc(1,15,1,0,0, 0,0, 0,0, 0,  0,0,0,1);
        end

        // md_cnt is 10 here: reset mid-cycle must clear everything at once
        @(posedge clock);
        #1;
        drive(1,9,1,0,0, 8,1, 15,1, 0);
        #1;
        reset_n = 1'b0;
        expect_out(0,0,0,0);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        cyc(1,9,1,0,0, 8,1, 15,1, 0,  0,0,0,0);
        cyc(1,10,1,0,0, 9,1, 0,0, 0,  0,1,0,0);

        @(negedge clock);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bypass_scoreboard.md
BYPASS_SCOREBOARD -- requirements
Module: bypass_scoreboard

Interface
REQ-001 SHALL have parameter REG_BITS, default 5, meaning register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, meaning the number of tracked in-flight stages after decode (2..7).
REQ-003 SHALL have parameter MD_CYCLES, default 33, meaning the multiply/divide latency in cycles (2..255).
REQ-004 SHALL have port clock, input, 1, the single clock; all state is on the rising edge.
REQ-005 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port issue_valid, input, 1, meaning the decode-stage instruction is real (not a bubble).
REQ-007 SHALL have port issue_rd, input, REG_BITS, the decode-stage destination register.
REQ-008 SHALL have ports issue_wen, issue_is_load and issue_is_md, each input, 1, meaning the instruction writes rd, is a load, and is a mult/div respectively.
REQ-009 SHALL have ports src_a and src_b, each input, REG_BITS, and src_a_used and src_b_used, each input, 1, giving the decode-stage sources and their qualifiers.
REQ-010 SHALL have port flush, input, 1, meaning a taken branch or jump squashes the decode-stage instruction.
REQ-011 SHALL have port stall, output, 1, meaning hold fetch/decode and insert a bubble.
REQ-012 SHALL have ports fwd_a and fwd_b, each output, 3: 0 = register file; k = stage k result (1..DEPTH).
REQ-013 SHALL have port md_busy, output, 1, meaning a mult/div is in flight.

Function
REQ-014 SHALL hold a tag pipeline entry[1..DEPTH], each entry being {v, rd, wen, ld}; entry[1] is the stage immediately after decode.
REQ-015 SHALL shift every cycle: entry[k+1] <= entry[k], and entry[DEPTH] retires.
REQ-016 SHALL load entry[1] with the issue fields when issue_valid & ~stall & ~flush; otherwise entry[1] SHALL become a bubble (v=0).
REQ-017 SHALL treat an entry as a producer only when v & wen & rd != 0; register 0 never forwards and never stalls.
REQ-018 For each used source, fwd SHALL select the smallest k whose producer rd equals the source (youngest wins); it SHALL be 0 if there is no match or the source is unused.
REQ-019 SHALL drive fwd_a, fwd_b and stall combinationally from the current state and inputs, with zero latency.
REQ-020 SHALL assert stall on load-use: a used source matching an entry[1] producer with ld=1.
REQ-021 A load at entry[k] with k >= 2 SHALL forward normally without stalling.
REQ-022 SHALL hold the mult/div state as md_cnt (8 bit) and md_rd; it is idle when md_cnt = 0.
REQ-023 SHALL start a mult/div on an accepted issue with issue_is_md: md_cnt <= MD_CYCLES and md_rd <= issue_rd.
REQ-024 The mult/div SHALL NOT also enter the tag pipeline as a producer; the wen of the entry[1] it loads SHALL be forced to 0.
REQ-025 While md_cnt != 0, md_cnt SHALL decrement by 1 every cycle; md_busy = (md_cnt != 0).
REQ-026 SHALL assert stall when md_busy and either a used source equals md_rd (md_rd != 0), or issue_is_md & issue_valid is set.
REQ-027 On the cycle md_cnt = 1, the result is written back; fwd SHALL NOT select it, and the dependent instruction SHALL issue the following cycle and read the register file.
REQ-028 Stall SHALL be qualified by issue_valid & ~flush; a bubble or a flushed slot never stalls.
REQ-029 With flush and stall conditions present in the same cycle, flush SHALL win: no stall, and a bubble is inserted.
REQ-030 flush SHALL NOT affect the entries already in the pipeline or the mult/div state.

Reset
REQ-031 Asserting reset_n low SHALL immediately clear all entry v bits, md_cnt and md_rd to 0, including mid-operation or mid-mult/div.
REQ-032 During reset, outputs SHALL be stall=0, fwd_a=0, fwd_b=0 and md_busy=0.
REQ-033 The first edge after reset_n rises SHALL accept an issue normally.

Verification
REQ-034 Back-to-back add r3 then add r4,r3,r3 -> next cycle fwd_a=1, fwd_b=1, stall=0; one cycle later, with an unrelated instruction between, fwd=2.
REQ-035 lw r5 then add r6,r5,r0 -> stall=1 for exactly 1 cycle, then fwd_a=2, stall=0.
REQ-036 Writes to r7 at entries 1 and 3 with src_a=r7 -> fwd_a=1; a write to r0 with src_a=r0 -> fwd_a=0, stall=0.
REQ-037 mul r8 (MD_CYCLES=33) followed by add r9,r8 -> stall high for 33 cycles, md_busy falls, add issues with fwd_a=0; an independent add during the mult/div -> no stall.
REQ-038 Load-use with flush=1 in the same cycle -> stall=0 and entry[1] is a bubble.
REQ-039 reset_n low at md_cnt=10 -> md_busy=0 and stall=0 asynchronously, and the pipeline is empty.
